ascon_perm_engine: RTL
======================

Name: ascon_perm_engine

Overview:
- Sequential round driver for the Ascon permutation p^a / p^b.
- Accepts a 320-bit state and a round count, then applies one combinational Ascon round per cycle with the correct round constant. The round itself is a ascon_permutation instance.
- Holds the result until downstream accepts it.
- Sits between the AEAD/hash mode controller (upstream) and the single-round ascon_permutation datapath.

Parameters:
- MAX_ROUNDS, 12, maximum rounds per request; fixed to 12 for Ascon compliance.
- CNT_W, 4, width of the round counter and num_rounds port.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request.
- state_in  input  320  state {x0,x1,x2,x3,x4}, x0 in [319:256].
- num_rounds  input  CNT_W  rounds to apply (legal 0..12).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- state_out  output  320  permuted state, valid while out_valid.
- busy  output  1  high in RUN.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-low on rst_n. All state changes occur on the rising edge.
- Reset values: FSM=IDLE, state register=0, round index=0, in_ready=1, out_valid=0, busy=0, state_out=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Handshake in_valid&in_ready latches state_in into the state register.
  - Round index = 12 - n, where n = min(num_rounds, 12); values 13..15 saturate to 12.
  - Remaining count = n.
  - If n=0, go to DONE with the state unchanged (out_valid next cycle). Otherwise go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle: state register <= round(state register, rc).
  - rc = {(4'hF - idx[3:0]), idx[3:0]}, giving the sequence 0xF0,0xE1,0xD2,0xC3,0xB4,0xA5,0x96,0x87,0x78,0x69,0x5A,0x4B for idx 0..11.
  - idx increments and remaining count decrements each cycle.
  - When the remaining count reaches 0 after the update, go to DONE.
- DONE:
  - out_valid=1; state_out = state register, stable until the handshake.
  - out_valid&out_ready returns to IDLE. in_ready rises the cycle after the handshake (no same-cycle reaccept).
- Latency: acceptance edge to out_valid = n cycles, or 1 cycle for n=0.
- Throughput: one request per n+2 cycles with out_ready held high.
- Inputs are ignored outside the IDLE handshake; state_in and num_rounds may change freely after acceptance.
- out_ready low in DONE: hold indefinitely, no state change.
- rst_n low mid-RUN or in DONE: abort and return to reset values on that edge; the partial state is discarded.
- in_valid and rst_n low together: reset wins.

Optional Feature:
- Macro: ASCON_PERM_UNROLL2_EN.
- Defined:
  - Two chained round instances per cycle, using constants rc(idx) and rc(idx+1); idx advances by 2 and the count decreases by 2.
  - If only 1 round remains, the second instance is bypassed, so exactly n rounds are applied.
  - Latency = ceil(n/2) cycles (n=12 -> 6, n=6 -> 3, n=1 -> 1).
- Undefined: one round per cycle as described above.
- Ports and handshake behaviour are identical in both builds.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> in_ready=1, out_valid=0, state_out=0, busy=0.
- num_rounds=12 with a random state:
  - out_valid asserts exactly 12 cycles after acceptance (6 with UNROLL2).
  - Probed rc sequence is 0xF0..0x4B.
  - state_out matches a software model of p^12.
- num_rounds=6:
  - First rc = 0x96, last rc = 0x4B.
  - Result matches model p^6; out_valid after 6 cycles (3 with UNROLL2).
- num_rounds=0 with state_in=320'h1234...:
  - out_valid the next cycle with state_out identical to the input.
  - num_rounds=15 produces the same result as num_rounds=12.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> state_out and out_valid stable, in_ready=0; raise out_ready -> IDLE, and in_ready=1 on the following cycle.
- Reset mid-RUN: assert rst_n=0 at round 5 of 12 -> all outputs return to reset values next edge; a new request then produces a correct p^12.

Source files
------------

// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - sequential Ascon p^a/p^b round driver with a single-round datapath.
// Optional ASCON_PERM_UNROLL2_EN chains two rounds per cycle.

module ascon_permutation (
  input  logic [319:0] state_in,
  input  logic [7:0]   rc,
  output logic [319:0] state_out
);
  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] b0, b2, b4;
  logic [63:0] c0, c1, c2, c3, c4;
  logic [63:0] d0, d1, d2, d3, d4;

  function automatic logic [63:0] ror(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  assign x0 = state_in[319:256];
  assign x1 = state_in[255:192];
  assign x2 = state_in[191:128] ^ {56'h0, rc};
  assign x3 = state_in[127:64];
  assign x4 = state_in[63:0];

  // Bit-sliced 5-bit S-box applied to all 64 columns at once
  assign b0 = x0 ^ x4;
  assign b4 = x4 ^ x3;
  assign b2 = x2 ^ x1;
  assign c0 = b0 ^ (~x1 & b2);
  assign c1 = x1 ^ (~b2 & x3);
  assign c2 = b2 ^ (~x3 & b4);
  assign c3 = x3 ^ (~b4 & b0);
  assign c4 = b4 ^ (~b0 & x1);
  assign d0 = c0 ^ c4;
  assign d1 = c1 ^ c0;
  assign d2 = ~c2;
  assign d3 = c3 ^ c2;
  assign d4 = c4;

  assign state_out = {d0 ^ ror(d0, 19) ^ ror(d0, 28),
                      d1 ^ ror(d1, 61) ^ ror(d1, 39),
                      d2 ^ ror(d2, 1)  ^ ror(d2, 6),
                      d3 ^ ror(d3, 10) ^ ror(d3, 17),
                      d4 ^ ror(d4, 7)  ^ ror(d4, 41)};
endmodule

module ascon_perm_engine #(
  parameter int MAX_ROUNDS = 12,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [319:0]     state_in,
  input  logic [CNT_W-1:0] num_rounds,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [319:0]     state_out,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam logic [CNT_W-1:0] MAXR = CNT_W'(MAX_ROUNDS);

  fsm_t             fsm_q, fsm_d;
  logic [319:0]     st_q, st_d;
  logic [CNT_W-1:0] idx_q, idx_d, rem_q, rem_d;
  logic [CNT_W-1:0] n_sat, step;
  logic [319:0]     round_out, r0;
  logic [7:0]       rc0;

  function automatic logic [7:0] rc_of(input logic [CNT_W-1:0] i);
    return {4'hF - i[3:0], i[3:0]};
  endfunction

  assign n_sat = (num_rounds > MAXR) ? MAXR : num_rounds;
  assign rc0   = rc_of(idx_q);

  ascon_permutation u_round0 (.state_in(st_q), .rc(rc0), .state_out(r0));

`ifdef ASCON_PERM_UNROLL2_EN
  logic [319:0] r1;
  logic [7:0]   rc1;
  assign rc1 = rc_of(idx_q + CNT_W'(1));
  ascon_permutation u_round1 (.state_in(r0), .rc(rc1), .state_out(r1));
  // A lone trailing round bypasses the second instance so exactly n rounds apply
  assign step      = (rem_q == CNT_W'(1)) ? CNT_W'(1) : CNT_W'(2);
  assign round_out = (rem_q == CNT_W'(1)) ? r0 : r1;
`else
  assign step      = CNT_W'(1);
  assign round_out = r0;
`endif

  always_comb begin
    fsm_d = fsm_q;
    st_d  = st_q;
    idx_d = idx_q;
    rem_d = rem_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = state_in;
          idx_d = MAXR - n_sat;
          rem_d = n_sat;
          fsm_d = (n_sat == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        st_d  = round_out;
        idx_d = idx_q + step;
        rem_d = rem_q - step;
        if (rem_q == step) fsm_d = DONE;
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      idx_q <= '0;
      rem_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      idx_q <= idx_d;
      rem_q <= rem_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE);
  assign busy      = (fsm_q == RUN);
  assign out_valid = (fsm_q == DONE);
  assign state_out = st_q;
endmodule
